spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Memory-mapped SPI master that drives the 40-bit frame our SPI slave peripheral expects, so one board can talk to another board's slave or to a loopback bench.
- The CPU writes a payload word and a command byte, then polls status and reads back the 32-bit word returned on MISO.
- The block sits on the data bus beside the existing peripherals and uses the same Data_WE / Data_Addr / Data_Write / Data_Read convention.

Parameters:
- CLK_DIV, 8: SCLK half-period in Clk cycles. Legal range 4..255. The minimum of 4 is set by the slave's single-stage synchroniser and our 2-FF MISO synchroniser.

Ports:
- Clk  in  1  system clock. All logic is on posedge Clk.
- Reset_n  in  1  asynchronous, active-low reset.
- Data_WE  in  1  bus write strobe.
- Data_Addr  in  32  byte address. Only [3:2] are decoded.
- Data_Write  in  32  bus write data.
- Data_Read  out  32  bus read data. Combinational from Data_Addr[3:2].
- SPI_CLK  out  1  SCLK, mode 0 (idle low).
- SPI_CS  out  1  chip select, active low.
- SPI_MOSI  out  1  serial data out, MSB first.
- SPI_MISO  in  1  serial data in. Asynchronous; synchronised with 2 FFs.

Behaviour:
- Register map (Data_Addr[3:2]):
  - 0 = CMD. Write [7:0] starts a transfer; reads return the last command.
  - 1 = TXDATA. Read/write.
  - 2 = RXDATA. Read-only; writes are ignored.
  - 3 = STATUS. bit0 busy, bit1 done (sticky); other bits read 0.
- Unmapped Data_Addr bits are ignored (aliasing).
- Reset values: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, CMD=0, TXDATA=0, RXDATA=0, busy=0, done=0. Reset mid-frame forces CS high immediately (async) and abandons the frame.
- Frame: 40 bits = {CMD[7:0], TXDATA[31:0]}, MSB first. CMD[7]=1 means a write to the remote register CMD[3:0]; CMD[7]=0 means a read. Remote reads return data on MISO bits 9..40.
- Starting a transfer: a CMD write while idle loads the 40-bit shift register from {Data_Write[7:0], TXDATA}, sets busy, and clears done.
  - A CMD write while busy is ignored entirely: CMD is not updated and the frame is unaffected.
  - TXDATA writes are accepted at any time and take effect on the next start.
  - CMD write and TXDATA write cannot occur in the same cycle (single bus).
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP. Each non-IDLE state lasts exactly CLK_DIV Clk cycles, timed by a divider counter.
  - IDLE: CS=1, SCLK=0. Moves to SETUP on start.
  - SETUP: CS=0, MOSI=frame[39]. Moves to HIGH.
  - HIGH: SCLK=1. In the last cycle of HIGH, capture the synchronised MISO into the rx shift register and increment the bit counter (6-bit).
    - Bit counter now 40: go to HOLD.
    - Otherwise: go to LOW.
  - LOW: SCLK=0. In the first cycle, shift the tx register so MOSI presents the next bit. Moves to HIGH.
  - HOLD: SCLK=0, CS=0. Moves to GAP.
  - GAP: CS=1. On exit: RXDATA <= rx[31:0] (atomic update), busy=0, done=1, then go to IDLE.
- Frame length: 40 rising SCLK edges. Total Clk cycles from the start write to busy=0 is 1 + 82*CLK_DIV, i.e. 657 at the default.
- SCLK, CS and MOSI are registered outputs (glitch-free).
- MISO bits 1..8 are captured but discarded.
- done is cleared by writing STATUS with bit1=1, or by a new start. If a clear and the GAP exit coincide, set wins.
- Simultaneous start and GAP exit cannot occur (busy is still 1 during GAP).

Decomposition:
- Shared package spi_pkg holds:
  - SPI_FRAME_BITS=40, SPI_CMD_BITS=8, SPI_WR_FLAG=7;
  - register offsets REG_CMD=0, REG_TX=1, REG_RX=2, REG_STAT=3;
  - the FSM state enum type.
- The slave is refactored to import the same frame constants.
- One natural sub-module: spi_clkgen. It holds the divider counter and emits phase_end pulses; the FSM stays in spi_master.

Test Plan:
- Reset: hold Reset_n=0 → CS=1, SCLK=0, MOSI=0, STATUS=0. Assert Reset_n mid-frame (bit 17) → CS high in the same cycle, busy=0, RXDATA unchanged.
- Remote write: TXDATA=0xDEADBEEF, CMD=0x85 → monitor decodes 40 MOSI bits 0x85DEADBEEF, exactly 40 SCLK rising edges, CS low throughout; busy clears after 657 cycles; done=1.
- Remote read: connect to a spi_slave model whose misoRAM[3]=0x12345678, write CMD=0x03 → RXDATA=0x12345678; the slave's mosiRAM is untouched.
- Busy protection: write CMD=0x81 mid-frame → frame bits unchanged, CMD still reads 0x85. Write TXDATA=0x1 mid-frame → current frame unchanged; the next frame carries 0x00000001.
- CLK_DIV=4 with MISO toggling at the slave's worst-case update latency → all 32 RX bits correct. Done clears on STATUS write of 0x2 and on the next start.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI frame constants, register offsets and master FSM state type.
// The slave peripheral imports the same frame constants.
package spi_pkg;
  localparam int SPI_FRAME_BITS = 40;
  localparam int SPI_CMD_BITS   = 8;
  localparam int SPI_WR_FLAG    = 7;

  localparam logic [1:0] REG_CMD  = 2'd0;
  localparam logic [1:0] REG_TX   = 2'd1;
  localparam logic [1:0] REG_RX   = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, HOLD, GAP
  } spi_state_t;
endpackage

// File: rtl/spi_clkgen.sv
// Phase timer for the SPI master: every non-idle FSM phase lasts CLK_DIV cycles.
// phase_start marks the first cycle of a phase, phase_end the last.
module spi_clkgen #(
  parameter int CLK_DIV = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic en,
  output logic phase_start,
  output logic phase_end
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign phase_end   = en && (cnt == CW'(CLK_DIV - 1));
  assign phase_start = en && (cnt == '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)               cnt <= '0;
    else if (!en || phase_end)  cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/spi_master.sv
// Memory-mapped SPI master (mode 0) issuing {CMD, TXDATA} 40-bit frames and
// collecting the last 32 MISO bits into RXDATA.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Data_WE,
  input  logic [31:0] Data_Addr,
  input  logic [31:0] Data_Write,
  output logic [31:0] Data_Read,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);
  spi_state_t                state;
  logic [SPI_CMD_BITS-1:0]   cmd_q;
  logic [31:0]               tx_q, rx_data, rx_sh;
  logic [SPI_FRAME_BITS-1:0] tx_sh;
  logic [5:0]                bit_cnt;
  logic                      done, busy;
  logic                      miso_s1, miso_s2;
  logic                      phase_start, phase_end;
  logic [1:0]                reg_sel;
  logic                      start;
  logic                      addr_unused;

  assign reg_sel     = Data_Addr[3:2];
  assign addr_unused = ^{Data_Addr[31:4], Data_Addr[1:0]};
  assign busy        = (state != IDLE);
  assign start       = Data_WE && (reg_sel == REG_CMD) && !busy;

  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .en          (busy),
    .phase_start (phase_start),
    .phase_end   (phase_end)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= SPI_MISO;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      SPI_CS   <= 1'b1;
      SPI_CLK  <= 1'b0;
      SPI_MOSI <= 1'b0;
      cmd_q    <= '0;
      tx_q     <= '0;
      rx_data  <= '0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      bit_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      if (Data_WE && reg_sel == REG_TX) tx_q <= Data_Write;
      if (Data_WE && reg_sel == REG_STAT && Data_Write[1]) done <= 1'b0;
      // later assignments to done (start clear, GAP set) override the bus clear
      case (state)
        IDLE: if (start) begin
          cmd_q    <= Data_Write[SPI_CMD_BITS-1:0];
          tx_sh    <= {Data_Write[SPI_CMD_BITS-1:0], tx_q};
          bit_cnt  <= '0;
          done     <= 1'b0;
          SPI_CS   <= 1'b0;
          SPI_MOSI <= Data_Write[SPI_CMD_BITS-1];
          state    <= SETUP;
        end
        SETUP: if (phase_end) begin
          SPI_CLK <= 1'b1;
          state   <= HIGH;
        end
        HIGH: if (phase_end) begin
          rx_sh   <= {rx_sh[30:0], miso_s2};
          bit_cnt <= bit_cnt + 1'b1;
          SPI_CLK <= 1'b0;
          state   <= (bit_cnt == 6'(SPI_FRAME_BITS - 1)) ? HOLD : LOW;
        end
        LOW: begin
          if (phase_start) begin
            tx_sh    <= {tx_sh[SPI_FRAME_BITS-2:0], 1'b0};
            SPI_MOSI <= tx_sh[SPI_FRAME_BITS-2];
          end
          if (phase_end) begin
            SPI_CLK <= 1'b1;
            state   <= HIGH;
          end
        end
        HOLD: if (phase_end) begin
          SPI_CS   <= 1'b1;
          SPI_MOSI <= 1'b0;
          state    <= GAP;
        end
        GAP: if (phase_end) begin
          rx_data <= rx_sh;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Data_Read = '0;
    case (reg_sel)
      REG_CMD:  Data_Read = {24'd0, cmd_q};
      REG_TX:   Data_Read = tx_q;
      REG_RX:   Data_Read = rx_data;
      REG_STAT: Data_Read = {30'd0, done, busy};
      default:  Data_Read = '0;
    endcase
  end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV 8 and 4), each wired to a
// behavioural SPI slave that decodes MOSI frames and serves MISO from a RAM.
module tb_spi_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  we;
  logic [31:0] addr, wdata;
  logic [31:0] rd [2];
  wire  [1:0]  sclk, cs, mosi, miso;
  logic [31:0] miso_ram [2][16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(8)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .Data_WE(we[0]), .Data_Addr(addr),
    .Data_Write(wdata), .Data_Read(rd[0]), .SPI_CLK(sclk[0]), .SPI_CS(cs[0]),
    .SPI_MOSI(mosi[0]), .SPI_MISO(miso[0])
  );

  spi_master #(.CLK_DIV(4)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .Data_WE(we[1]), .Data_Addr(addr),
    .Data_Write(wdata), .Data_Read(rd[1]), .SPI_CLK(sclk[1]), .SPI_CS(cs[1]),
    .SPI_MOSI(mosi[1]), .SPI_MISO(miso[1])
  );

  // Slave: two-stage edge detect on SCLK/CS gives the worst-case MISO latency.
  for (genvar g = 0; g < 2; g++) begin : sl
    logic        sclk_q = 1'b0, sclk_q2 = 1'b0, cs_q = 1'b1, cs_q2 = 1'b1;
    logic        miso_r = 1'b0, cs_bad = 1'b0;
    int          cnt = 0;
    logic [39:0] sh_in = '0;
    logic [31:0] sh_out = '0;
    logic [31:0] mosi_ram [16] = '{default: '0};

    assign miso[g] = miso_r;

    always @(posedge clk) begin
      sclk_q  <= sclk[g];
      sclk_q2 <= sclk_q;
      cs_q    <= cs[g];
      cs_q2   <= cs_q;
      if (sclk[g] && cs[g]) cs_bad <= 1'b1;
      if (!cs_q && cs_q2) cnt <= 0;
      else if (!cs_q && sclk_q && !sclk_q2) begin
        sh_in <= {sh_in[38:0], mosi[g]};
        cnt   <= cnt + 1;
        if (cnt == 7 && !sh_in[6]) sh_out <= miso_ram[g][{sh_in[2:0], mosi[g]}];
        if (cnt == 39 && sh_in[38]) mosi_ram[sh_in[34:31]] <= {sh_in[30:0], mosi[g]};
      end else if (!cs_q && !sclk_q && sclk_q2 && cnt >= 8) begin
        miso_r <= sh_out[31];
        sh_out <= {sh_out[30:0], 1'b0};
      end
    end
  end

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(int d, logic [31:0] a, logic [31:0] v);
    addr  = a;
    wdata = v;
    we[d] = 1'b1;
    @(posedge clk);
    #1 we = '0;
  endtask

  task automatic bus_rd(int d, logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1 v = rd[d];
  endtask

  // n = write cycle plus every cycle busy reads 1
  task automatic wait_idle(int d, output int n);
    logic [31:0] s;
    n = 1;
    bus_rd(d, 32'hC, s);
    while (s[0] && n < 30000) begin
      n++;
      @(posedge clk);
      #1;
      bus_rd(d, 32'hC, s);
    end
    if (s[0]) begin
      errors++;
      $display("FAIL wait_idle dut%0d: busy still %0d after %0d cycles, required 0", d, s[0], n);
    end
  endtask

  task automatic wait_bit0(int target);
    int guard = 0;
    while (sl[0].cnt != target && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check($sformatf("reach_bit%0d", target), 64'(sl[0].cnt), 64'(target));
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [12];
    logic [31:0] v;
    int          n;

    tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0};
    tbl[2]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0};
    tbl[3]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 32'h1234_5674, 32'hCAFE_F00D, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hCAFE_F00D};
    tbl[6]  = '{1'b0, 32'hFFFF_FFF7, 32'h0,         32'hCAFE_F00D};
    tbl[7]  = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0};
    tbl[9]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0};

    for (int i = 0; i < 16; i++) begin
      miso_ram[0][i] = 32'h0;
      miso_ram[1][i] = 32'h0;
    end
    miso_ram[0][3]  = 32'h1234_5678;
    miso_ram[1][9]  = 32'hAAAA_5555;
    miso_ram[1][10] = 32'h3C3C_C3C3;
    miso_ram[1][11] = 32'h0F0F_F0F0;

    rst_n = 1'b0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs0",   64'(cs[0]),   64'd1);
    check("rst_sclk0", 64'(sclk[0]), 64'd0);
    check("rst_mosi0", 64'(mosi[0]), 64'd0);
    check("rst_cs1",   64'(cs[1]),   64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) bus_wr(0, tbl[i].a, tbl[i].d);
      else begin
        bus_rd(0, tbl[i].a, v);
        check($sformatf("reg_vec%0d", i), 64'(v), 64'(tbl[i].exp));
      end
    end

    // Reset in the middle of a frame
    bus_wr(0, 32'h4, 32'h0F0F_0F0F);
    bus_wr(0, 32'h0, 32'h85);
    wait_bit0(17);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_cs",   64'(cs[0]),   64'd1);
    check("midrst_sclk", 64'(sclk[0]), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus_rd(0, 32'hC, v); check("midrst_status", 64'(v), 64'd0);
    bus_rd(0, 32'h8, v); check("midrst_rx",     64'(v), 64'd0);
    bus_rd(0, 32'h0, v); check("midrst_cmd",    64'(v), 64'd0);
    @(posedge clk);
    #1;

    // Remote write
    bus_wr(0, 32'h4, 32'hDEAD_BEEF);
    bus_wr(0, 32'h0, 32'h85);
    bus_rd(0, 32'hC, v); check("wr_busy", 64'(v), 64'd1);
    wait_idle(0, n);
    check("wr_cycles", 64'(n), 64'd657);
    check("wr_frame",  64'(sl[0].sh_in), 64'h85_DEAD_BEEF);
    check("wr_edges",  64'(sl[0].cnt), 64'd40);
    check("wr_cs_low", 64'(sl[0].cs_bad), 64'd0);
    check("wr_ram5",   64'(sl[0].mosi_ram[5]), 64'hDEAD_BEEF);
    bus_rd(0, 32'hC, v); check("wr_done", 64'(v), 64'd2);
    bus_rd(0, 32'h0, v); check("wr_cmd",  64'(v), 64'h85);

    // Writes during a frame
    bus_wr(0, 32'h0, 32'h85);
    wait_bit0(10);
    bus_wr(0, 32'h0, 32'h81);
    bus_wr(0, 32'h4, 32'h0000_0001);
    bus_rd(0, 32'h0, v); check("busy_cmd_kept", 64'(v), 64'h85);
    wait_idle(0, n);
    check("busy_frame", 64'(sl[0].sh_in), 64'h85_DEAD_BEEF);
    bus_wr(0, 32'h0, 32'h85);
    wait_idle(0, n);
    check("next_frame", 64'(sl[0].sh_in), 64'h85_0000_0001);
    check("next_ram5",  64'(sl[0].mosi_ram[5]), 64'h1);

    // Remote read
    bus_wr(0, 32'h4, 32'h0);
    bus_wr(0, 32'h0, 32'h03);
    wait_idle(0, n);
    check("rd_cycles", 64'(n), 64'd657);
    bus_rd(0, 32'h8, v); check("rd_rxdata", 64'(v), 64'h1234_5678);
    check("rd_ram3_untouched", 64'(sl[0].mosi_ram[3]), 64'h0);
    bus_rd(0, 32'hC, v); check("rd_done", 64'(v), 64'd2);

    // CLK_DIV=4: minimum divider, toggling MISO
    bus_wr(1, 32'h0, 32'h09);
    wait_idle(1, n);
    check("d4_cycles", 64'(n), 64'd329);
    bus_rd(1, 32'h8, v); check("d4_rx",   64'(v), 64'hAAAA_5555);
    bus_rd(1, 32'hC, v); check("d4_done", 64'(v), 64'd2);
    bus_wr(1, 32'hC, 32'h1);
    bus_rd(1, 32'hC, v); check("d4_noclear", 64'(v), 64'd2);
    bus_wr(1, 32'hC, 32'h2);
    bus_rd(1, 32'hC, v); check("d4_clear", 64'(v), 64'd0);

    // Clear write landing on the GAP-exit edge: set must win
    bus_wr(1, 32'h0, 32'h0A);
    repeat (82 * 4 - 1) @(posedge clk);
    #1;
    bus_wr(1, 32'hC, 32'h2);
    bus_rd(1, 32'hC, v); check("d4_set_wins", 64'(v), 64'd2);
    bus_rd(1, 32'h8, v); check("d4_rx2", 64'(v), 64'h3C3C_C3C3);

    // New start clears done
    bus_wr(1, 32'h0, 32'h0B);
    bus_rd(1, 32'hC, v); check("d4_start_clr", 64'(v), 64'd1);
    wait_idle(1, n);
    bus_rd(1, 32'h8, v); check("d4_rx3",  64'(v), 64'h0F0F_F0F0);
    bus_rd(1, 32'hC, v); check("d4_done3", 64'(v), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
